// File: rtl/ntcrack_host_pkg.sv
// Shared types and byte codes for the ntcrack host sequencer.
package ntcrack_host_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LD_RX,
      ST_LD_TURN,
      ST_LD_SETUP,
      ST_LD_PULSE,
      ST_SR_WAIT,
      ST_SR_GO,
      ST_SR_RESULT,
      ST_TX_HDR,
      ST_RD_TURN,
      ST_RD_TX,
      ST_RD_GO,
      ST_TX_DONE,
      ST_TX_ACK,
      ST_TX_ERR
   } state_t;

   localparam logic [7:0] CMD_LOAD   = 8'h01;
   localparam logic [7:0] CMD_SEARCH = 8'h02;
   localparam logic [7:0] RSP_MATCH  = 8'h80;
   localparam logic [7:0] RSP_DONE   = 8'h81;
   localparam logic [7:0] RSP_ACK    = 8'hA1;
   localparam logic [7:0] RSP_ERR    = 8'hEE;

   // States in which a response byte is offered to the host.
   function automatic logic is_tx_state(state_t s);
      return (s == ST_TX_HDR) || (s == ST_RD_TX) || (s == ST_TX_DONE) ||
             (s == ST_TX_ACK) || (s == ST_TX_ERR);
   endfunction

endpackage

// File: rtl/ntcrack_host_sequencer_if.sv
// Host byte-stream bundle: one receive channel and one transmit channel.
interface ntcrack_host_sequencer_if;
   // Each channel transfers one byte on a rising clk edge where valid && ready;
   // a raised valid keeps its data stable until that edge, and ready never waits on valid.
   logic [7:0] host_rx_data;
   logic       host_rx_valid;
   logic       host_rx_ready;
   logic [7:0] host_tx_data;
   logic       host_tx_valid;
   logic       host_tx_ready;

   modport master (
      output host_rx_data, host_rx_valid, host_tx_ready,
      input  host_rx_ready, host_tx_data, host_tx_valid
   );

   modport slave (
      input  host_rx_data, host_rx_valid, host_tx_ready,
      output host_rx_ready, host_tx_data, host_tx_valid
   );
endinterface

// File: rtl/ntcrack_strobe_gen.sv
// Fixed-width strobe after a one-cycle start, then one guard cycle flagged by done.
module ntcrack_strobe_gen #(
   parameter int PULSE_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic strobe,
   output logic done
);

   localparam int CW = $clog2(PULSE_CYCLES + 2);
   localparam logic [CW-1:0] LAST  = CW'(PULSE_CYCLES);
   localparam logic [CW-1:0] GUARD = CW'(PULSE_CYCLES + 1);

   // phase 0 = idle, 1..LAST = strobe high, GUARD = quiet cycle before resuming
   logic [CW-1:0] phase;
   logic [CW-1:0] phase_n;

   always_comb begin
      phase_n = phase;
      if (phase == '0) begin
         if (start) phase_n = CW'(1);
      end else if (phase == GUARD) begin
         phase_n = '0;
      end else begin
         phase_n = phase + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase  <= '0;
         strobe <= 1'b0;
      end else begin
         phase  <= phase_n;
         strobe <= (phase_n != '0) && (phase_n <= LAST);
      end
   end

   assign done = (phase == GUARD);

endmodule

// File: rtl/ntcrack_host_sequencer.sv
// Turns host LOAD/SEARCH commands into paced cracker strobes and streams matches back.
module ntcrack_host_sequencer
   import ntcrack_host_pkg::*;
#(
   parameter int HASH_BYTES   = 16,
   parameter int PW_BYTES     = 21,
   parameter int PULSE_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   ntcrack_host_sequencer_if.slave  host,
   output logic [7:0]               new_hash_byte,
   output logic                     store_hash_byte,
   output logic                     go,
   input  logic                     my_turn,
   input  logic                     match_found,
   input  logic [7:0]               password_byte,
   output logic                     busy,
   output state_t                   dbg_state
);

   localparam int HW  = $clog2(HASH_BYTES + 1);
   localparam int PWW = $clog2(PW_BYTES + 1);

   state_t         state, state_n;
   logic [HW-1:0]  hash_cnt, hash_cnt_n, cnt_inc;
   logic [PWW-1:0] pw_idx, pw_idx_n, idx_inc;
   logic [7:0]     hash_byte, hash_byte_n;
   logic [7:0]     tx_data, tx_data_n;
   logic           rx_ready_q, tx_valid_q;
   logic           rx_fire, tx_fire;
   logic           start_store, start_go;
   logic           store_done, go_done;

   assign rx_fire = host.host_rx_valid && rx_ready_q;
   assign tx_fire = tx_valid_q && host.host_tx_ready;
   assign cnt_inc = hash_cnt + HW'(1);
   assign idx_inc = pw_idx + PWW'(1);

   always_comb begin
      state_n     = state;
      hash_cnt_n  = hash_cnt;
      pw_idx_n    = pw_idx;
      hash_byte_n = hash_byte;
      tx_data_n   = tx_data;
      start_store = 1'b0;
      start_go    = 1'b0;
      unique case (state)
         ST_IDLE: if (rx_fire) begin
            if (host.host_rx_data == CMD_LOAD) begin
               hash_cnt_n = '0;
               state_n    = ST_LD_RX;
            end else if (host.host_rx_data == CMD_SEARCH) begin
               state_n = ST_SR_WAIT;
            end else begin
               tx_data_n = RSP_ERR;
               state_n   = ST_TX_ERR;
            end
         end
         ST_LD_RX: if (rx_fire) begin
            hash_byte_n = host.host_rx_data;
            state_n     = ST_LD_TURN;
         end
         ST_LD_TURN:  if (my_turn) state_n = ST_LD_SETUP;
         // new_hash_byte has been stable since LD_RX; strobe rises the cycle after this one
         ST_LD_SETUP: begin
            start_store = 1'b1;
            state_n     = ST_LD_PULSE;
         end
         ST_LD_PULSE: if (store_done) begin
            hash_cnt_n = cnt_inc;
            if (cnt_inc == HW'(HASH_BYTES)) begin
               tx_data_n = RSP_ACK;
               state_n   = ST_TX_ACK;
            end else begin
               state_n = ST_LD_RX;
            end
         end
         ST_SR_WAIT: if (my_turn) begin
            start_go = 1'b1;
            state_n  = ST_SR_GO;
         end
         ST_SR_GO: if (go_done) state_n = ST_SR_RESULT;
         ST_SR_RESULT: if (my_turn) begin
            if (match_found) begin
               tx_data_n = RSP_MATCH;
               pw_idx_n  = '0;
               state_n   = ST_TX_HDR;
            end else begin
               tx_data_n = RSP_DONE;
               state_n   = ST_TX_DONE;
            end
         end
         ST_TX_HDR: if (tx_fire) state_n = ST_RD_TURN;
         ST_RD_TURN: if (my_turn) begin
            tx_data_n = password_byte;
            state_n   = ST_RD_TX;
         end
         // the cracker only advances once the host has taken the current byte
         ST_RD_TX: if (tx_fire) begin
            start_go = 1'b1;
            state_n  = ST_RD_GO;
         end
         ST_RD_GO: if (go_done) begin
            pw_idx_n = idx_inc;
            state_n  = (idx_inc == PWW'(PW_BYTES)) ? ST_SR_RESULT : ST_RD_TURN;
         end
         ST_TX_DONE, ST_TX_ACK, ST_TX_ERR: if (tx_fire) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         hash_cnt   <= '0;
         pw_idx     <= '0;
         hash_byte  <= '0;
         tx_data    <= '0;
         rx_ready_q <= 1'b0;
         tx_valid_q <= 1'b0;
      end else begin
         state      <= state_n;
         hash_cnt   <= hash_cnt_n;
         pw_idx     <= pw_idx_n;
         hash_byte  <= hash_byte_n;
         tx_data    <= tx_data_n;
         rx_ready_q <= (state_n == ST_IDLE) || (state_n == ST_LD_RX);
         tx_valid_q <= is_tx_state(state_n);
      end
   end

   ntcrack_strobe_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_store (
      .clk    (clk),
      .reset  (reset),
      .start  (start_store),
      .strobe (store_hash_byte),
      .done   (store_done)
   );

   ntcrack_strobe_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_go (
      .clk    (clk),
      .reset  (reset),
      .start  (start_go),
      .strobe (go),
      .done   (go_done)
   );

   assign host.host_rx_ready = rx_ready_q;
   assign host.host_tx_valid = tx_valid_q;
   assign host.host_tx_data  = tx_data;
   assign new_hash_byte      = hash_byte;
   assign busy               = (state != ST_IDLE);
   assign dbg_state          = state;

endmodule

// File: tb/tb_ntcrack_host_sequencer.sv
// Bench: random host/cracker timing against a dictionary-based cracker model and byte scoreboards.
module tb_ntcrack_host_sequencer;
   import ntcrack_host_pkg::*;

   localparam int HASH_BYTES = 16;
   localparam int PW_BYTES   = 21;
   localparam logic [127:0] H1 = 128'h588FEB889288FB953B5F094D47D1565C;
   localparam logic [127:0] H2 = 128'h91D533DC611AC2774431E2D0BAF36805;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ntcrack_host_sequencer_if host_if();
   logic [7:0] new_hash_byte, password_byte;
   logic       store_hash_byte, go, my_turn, match_found, busy;
   state_t     dbg_state;

   ntcrack_host_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .host            (host_if.slave),
      .new_hash_byte   (new_hash_byte),
      .store_hash_byte (store_hash_byte),
      .go              (go),
      .my_turn         (my_turn),
      .match_found     (match_found),
      .password_byte   (password_byte),
      .busy            (busy),
      .dbg_state       (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   logic [7:0]   exp_q[$];
   logic [7:0]   hq[$];
   logic [127:0] loaded[$];

   // dictionary of the cracker: hash -> password index
   function automatic int lookup(input logic [127:0] h);
      if (h == H1) return 0;
      if (h == H2) return 1;
      return -1;
   endfunction

   function automatic logic [7:0] pw_byte(input int m, input int i);
      string s;
      s = (m == 0) ? "12" : "!?";
      if (i == PW_BYTES - 1) return 8'(s.len());
      if (i < s.len()) return s[i];
      return 8'h00;
   endfunction

   // ---------------- cracker model ----------------
   logic [127:0] hash_list[$];
   logic [127:0] acc;
   int  acc_n = 0;
   int  pending[$];
   int  rd_idx = 0;
   int  store_cnt = 0, go_cnt = 0;
   int  store_w = 0, go_w = 0;
   bit  store_prev = 0, go_prev = 0, turn_seen = 0;
   logic [7:0] nhb_prev = 8'h00;

   initial begin
      logic [7:0] e;
      my_turn = 1'b0; match_found = 1'b0; password_byte = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            store_prev = 0; go_prev = 0; store_w = 0; go_w = 0; turn_seen = 0;
         end else begin
            if (store_hash_byte) begin
               if (!store_prev) begin
                  store_cnt++;
                  check("store_after_turn", 32'(turn_seen), 32'd1);
                  turn_seen = 0;
                  if (hq.size() == 0) check("store_unexpected", 32'(new_hash_byte), 32'h100);
                  else begin
                     e = hq.pop_front();
                     check("hash_byte", 32'(new_hash_byte), 32'(e));
                     check("hash_setup", 32'(nhb_prev), 32'(e));
                  end
                  acc[8*acc_n +: 8] = new_hash_byte;
                  acc_n++;
                  if (acc_n == HASH_BYTES) begin
                     hash_list.push_back(acc);
                     acc_n = 0;
                  end
               end
               store_w++;
            end else if (store_prev) begin
               check("store_width", 32'(store_w), 32'd2);
               store_w = 0;
            end
            if (go) begin
               if (!go_prev) begin
                  go_cnt++;
                  check("go_after_turn", 32'(turn_seen), 32'd1);
                  turn_seen = 0;
                  if (pending.size() == 0) begin
                     foreach (hash_list[k]) if (lookup(hash_list[k]) >= 0) pending.push_back(lookup(hash_list[k]));
                     rd_idx = 0;
                  end else begin
                     rd_idx++;
                     if (rd_idx == PW_BYTES) begin
                        void'(pending.pop_front());
                        rd_idx = 0;
                     end
                  end
               end
               go_w++;
            end else if (go_prev) begin
               check("go_width", 32'(go_w), 32'd2);
               go_w = 0;
            end
            if (my_turn && !store_hash_byte && !go) turn_seen = 1;
            store_prev = store_hash_byte;
            go_prev    = go;
            nhb_prev   = new_hash_byte;
         end
         @(posedge clk); #1;
         if (store_hash_byte || go) my_turn = 1'b0;
         else my_turn = ($urandom_range(0, 2) != 0);
         match_found   = (pending.size() != 0);
         password_byte = (pending.size() != 0) ? pw_byte(pending[0], rd_idx) : 8'h00;
      end
   end

   // ---------------- host tx side ----------------
   bit stall = 0;
   int tx_rcv = 0;

   initial begin
      host_if.host_tx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         host_if.host_tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset && host_if.host_tx_valid && host_if.host_tx_ready) begin
            tx_rcv++;
            if (exp_q.size() == 0) check("tx_unexpected", 32'(host_if.host_tx_data), 32'h100);
            else check("tx_byte", 32'(host_if.host_tx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      host_if.host_rx_data  = b;
      host_if.host_rx_valid = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (host_if.host_rx_ready) begin
            @(posedge clk); #1;
            host_if.host_rx_valid = 1'b0;
            return;
         end
      end
      check("rx_accept_timeout", 32'(host_if.host_rx_ready), 32'd1);
      host_if.host_rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0 && hq.size() == 0) return;
      end
      check("idle_timeout", (busy ? 32'h8000_0000 : 32'h0) | 32'(exp_q.size() + hq.size()), 32'd0);
   endtask

   task automatic load_hash(input logic [127:0] h);
      int s0;
      s0 = store_cnt;
      exp_q.push_back(RSP_ACK);
      send_byte(CMD_LOAD);
      for (int k = 0; k < HASH_BYTES; k++) begin
         hq.push_back(h[8*k +: 8]);
         send_byte(h[8*k +: 8]);
      end
      loaded.push_back(h);
      wait_idle();
      check("load_store_pulses", 32'(store_cnt - s0), 32'(HASH_BYTES));
      check("load_last_byte", 32'(new_hash_byte), 32'(h[127:120]));
   endtask

   function automatic int expect_search();
      int nm;
      nm = 0;
      foreach (loaded[k]) begin
         if (lookup(loaded[k]) >= 0) begin
            nm++;
            exp_q.push_back(RSP_MATCH);
            for (int i = 0; i < PW_BYTES; i++) exp_q.push_back(pw_byte(lookup(loaded[k]), i));
         end
      end
      exp_q.push_back(RSP_DONE);
      return nm;
   endfunction

   task automatic search();
      int g0, nm;
      g0 = go_cnt;
      nm = expect_search();
      send_byte(CMD_SEARCH);
      wait_idle();
      check("search_go_pulses", 32'(go_cnt - g0), 32'(1 + PW_BYTES * nm));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_ready"}, 32'(host_if.host_rx_ready), 32'd0);
      check({tag, "_tx_valid"}, 32'(host_if.host_tx_valid), 32'd0);
      check({tag, "_tx_data"},  32'(host_if.host_tx_data),  32'd0);
      check({tag, "_nhb"},      32'(new_hash_byte),         32'd0);
      check({tag, "_store"},    32'(store_hash_byte),       32'd0);
      check({tag, "_go"},       32'(go),                    32'd0);
      check({tag, "_busy"},     32'(busy),                  32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int g0, s0, nm, base;
      logic [7:0] b;
      reset = 1'b1;
      host_if.host_rx_data  = 8'h00;
      host_if.host_rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      reset = 1'b0;
      @(posedge clk); #1;

      load_hash(H1);
      search();

      load_hash(H2);
      search();

      // illegal commands
      for (int t = 0; t < 4; t++) begin
         b = (t == 0) ? 8'h7F : 8'($urandom_range(3, 255));
         s0 = store_cnt; g0 = go_cnt;
         exp_q.push_back(RSP_ERR);
         send_byte(b);
         wait_idle();
         check("err_busy", 32'(busy), 32'd0);
         check("err_no_store", 32'(store_cnt - s0), 32'd0);
         check("err_no_go", 32'(go_cnt - g0), 32'd0);
      end

      // host stalls mid-password
      g0 = go_cnt;
      nm = expect_search();
      base = tx_rcv;
      send_byte(CMD_SEARCH);
      for (int n = 0; n < 3000 && tx_rcv - base < 5; n++) @(negedge clk);
      check("stall_reached", 32'(tx_rcv - base >= 5), 32'd1);
      stall = 1;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (host_if.host_tx_valid && !host_if.host_tx_ready) break;
      end
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         check("stall_valid", 32'(host_if.host_tx_valid), 32'd1);
         check("stall_go", 32'(go), 32'd0);
         check("stall_data", 32'(host_if.host_tx_data), 32'(exp_q[0]));
      end
      stall = 0;
      wait_idle();
      check("stall_go_pulses", 32'(go_cnt - g0), 32'(1 + PW_BYTES * nm));

      // reset in the middle of a LOAD
      send_byte(CMD_LOAD);
      for (int k = 0; k < 5; k++) begin
         hq.push_back(H2[8*k +: 8]);
         send_byte(H2[8*k +: 8]);
      end
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (store_hash_byte) break;
      end
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      exp_q.delete(); hq.delete(); loaded.delete();
      hash_list.delete(); pending.delete(); acc_n = 0; rd_idx = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      load_hash(H1);
      search();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
